// File: rtl/pipeline_defs.sv
// Shared definitions for the pipeline run/step sequencer: FSM state encoding,
// the halt opcode and the default drain depth.
package pipeline_defs;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_STEP_WAIT = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_HALTED    = 3'd4
  } run_state_t;

  localparam logic [5:0] HALT_OPCODE          = 6'b111111;
  localparam int         DEFAULT_DRAIN_CYCLES = 3;

endpackage

// File: rtl/sat_counter.sv
// WIDTH-bit up counter with enable that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_run_ctrl.sv
// Run/step sequencer for the 5-stage pipeline: gates PC and pipeline enables,
// drains on halt and reports completion. Optional watchdog: PIPE_CTRL_WATCHDOG_EN.
module pipeline_run_ctrl
  import pipeline_defs::*;
#(
  parameter int N_BITS       = 32,
  parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES
`ifdef PIPE_CTRL_WATCHDOG_EN
  ,
  parameter logic [31:0] MAX_CYCLES = 32'hFFFF
`endif
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_run,
  input  logic              i_step,
  input  logic              i_halt_detected,
  input  logic              i_stall,
  output logic              o_pc_enable,
  output logic              o_pipe_enable,
  output logic              o_valid,
  output logic              o_halt,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_timeout,
  output logic [N_BITS-1:0] o_cycle_count
);

  localparam int                  DRAIN_W    = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DRAIN_W-1:0]  DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);

  run_state_t         state, state_next;
  logic               adv, adv_next;
  logic               from_step, from_step_next;
  logic [DRAIN_W-1:0] drain_cnt, drain_cnt_next;
  logic               halt_seen;
  logic               wd_hit;
  logic               timeout;

  assign halt_seen = adv & i_halt_detected;

`ifdef PIPE_CTRL_WATCHDOG_EN
  localparam logic [N_BITS-1:0] WD_LAST = N_BITS'(MAX_CYCLES - 32'd1);

  // Fire on the advance that brings the count up to the limit, so the drain
  // starts with the counter reading exactly MAX_CYCLES.
  assign wd_hit = adv && (o_cycle_count >= WD_LAST);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      timeout <= 1'b0;
    end else if ((state == ST_RUN || state == ST_STEP_WAIT) && wd_hit && !halt_seen) begin
      timeout <= 1'b1;
    end
  end
`else
  assign wd_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state     <= ST_IDLE;
      adv       <= 1'b0;
      from_step <= 1'b0;
      drain_cnt <= '0;
    end else begin
      state     <= state_next;
      adv       <= adv_next;
      from_step <= from_step_next;
      drain_cnt <= drain_cnt_next;
    end
  end

  always_comb begin
    state_next     = state;
    adv_next       = 1'b0;
    from_step_next = from_step;
    drain_cnt_next = drain_cnt;
    unique case (state)
      ST_IDLE: begin
        if (i_run) begin
          state_next = ST_RUN;
          adv_next   = 1'b1;
        end else if (i_step) begin
          state_next = ST_STEP_WAIT;
          adv_next   = 1'b1;
        end
      end
      ST_RUN: begin
        adv_next = 1'b1;
        if (halt_seen || wd_hit) begin
          state_next     = ST_DRAIN;
          drain_cnt_next = DRAIN_LOAD;
          from_step_next = 1'b0;
        end
      end
      ST_STEP_WAIT: begin
        if (halt_seen || wd_hit) begin
          state_next     = ST_DRAIN;
          drain_cnt_next = DRAIN_LOAD;
          from_step_next = 1'b1;
          adv_next       = i_step;
        end else if (i_run) begin
          state_next = ST_RUN;
          adv_next   = 1'b1;
        end else begin
          adv_next = i_step;
        end
      end
      ST_DRAIN: begin
        // A step-origin drain only moves when the user steps it.
        adv_next = from_step ? i_step : 1'b1;
        if (adv) begin
          drain_cnt_next = drain_cnt - DRAIN_W'(1);
          if (drain_cnt <= DRAIN_W'(1)) begin
            state_next = ST_HALTED;
            adv_next   = 1'b0;
          end
        end
      end
      ST_HALTED: begin
        adv_next = 1'b0;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    o_pipe_enable = adv;
    o_valid       = adv;
    o_pc_enable   = adv & ~i_stall & (state != ST_DRAIN);
    o_halt        = (state == ST_DRAIN) || (state == ST_HALTED);
    o_busy        = (state == ST_RUN) || (state == ST_DRAIN);
    o_done        = (state == ST_HALTED);
    o_timeout     = timeout;
  end

  sat_counter #(
    .WIDTH(N_BITS)
  ) u_cycle_counter (
    .clk  (i_clk),
    .rst_n(i_reset),
    .en   (adv),
    .count(o_cycle_count)
  );

endmodule
